// File: rtl/fetch_queue_stage.sv
// Instruction fetch stage: PC generation, req/gnt/rvalid fetch, in-order
// instruction queue and the IF/ID register consumed by decode.
module fetch_queue_stage #(
  parameter int unsigned       ADDR_W     = 32,
  parameter int unsigned       DEPTH      = 2,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
  parameter logic [31:0]       NOP_INS    = 32'h0000_0013
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              dbg_i,
  input  logic              mem_hold_i,
  input  logic              hz_i,
  input  logic              branch_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  input  logic              trap_i,
  input  logic [ADDR_W-1:0] trap_addr_i,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_gnt_i,
  input  logic              imem_rvalid_i,
  input  logic [31:0]       imem_rdata_i,
  output logic [31:0]       ins_o,
  output logic [ADDR_W-1:0] if_id_pres_addr_o,
  output logic              if_id_valid_o
);

  // state | meaning
  // IDLE  | first cycle after reset, no fetch issued
  // RUN   | normal fetch
  // DRAIN | fetching at redirected PC while stale responses are dropped
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_e;

  localparam int unsigned PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW      = PW + 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  state_e state_q, state_d;
  logic   issue_en;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [CW-1:0]     out_q, out_d, disc_q, disc_d;

  logic [ADDR_W-1:0] af_mem_q [DEPTH];
  logic [PW-1:0]     af_rd_q, af_rd_d, af_wr_q, af_wr_d;

  logic [ADDR_W-1:0] iq_addr_q [DEPTH];
  logic [31:0]       iq_data_q [DEPTH];
  logic [PW-1:0]     iq_rd_q, iq_rd_d, iq_wr_q, iq_wr_d;
  logic [CW-1:0]     iq_cnt_q, iq_cnt_d;

  logic [31:0]       ins_q, ins_d;
  logic [ADDR_W-1:0] pa_q, pa_d;
  logic              vld_q, vld_d;

  logic [CW:0]       inflight;
  logic              acc, resp, drop, keep, redirect, if_en, pop, push;
  logic [ADDR_W-1:0] target;

  // Capacity counts both queued and in-flight words so a response always fits.
  assign inflight    = {1'b0, out_q} + {1'b0, iq_cnt_q};
  assign imem_req_o  = issue_en && !dbg_i && (inflight < DEPTH_W);
  assign imem_addr_o = pc_q;

  assign acc      = imem_req_o && imem_gnt_i;
  assign resp     = imem_rvalid_i && (out_q != '0);
  assign drop     = resp && (disc_q != '0);
  assign keep     = resp && !drop;
  assign redirect = !dbg_i && (trap_i || branch_i);
  assign target   = trap_i ? trap_addr_i : branch_target_i;
  assign if_en    = !dbg_i && !mem_hold_i && !hz_i;
  assign pop      = if_en && !redirect && (iq_cnt_q != '0);
  assign push     = keep && !redirect;

  always_comb begin
    out_d = out_q;
    if (acc && !resp)      out_d = out_q + CW'(1);
    else if (!acc && resp) out_d = out_q - CW'(1);

    disc_d = disc_q;
    if (redirect)  disc_d = out_d;
    else if (drop) disc_d = disc_q - CW'(1);

    pc_d = pc_q;
    if (redirect) pc_d = target;
    else if (acc) pc_d = pc_q + ADDR_W'(4);

    af_wr_d  = redirect ? '0 : (acc  ? af_wr_q + PW'(1) : af_wr_q);
    af_rd_d  = redirect ? '0 : (keep ? af_rd_q + PW'(1) : af_rd_q);
    iq_wr_d  = redirect ? '0 : (push ? iq_wr_q + PW'(1) : iq_wr_q);
    iq_rd_d  = redirect ? '0 : (pop  ? iq_rd_q + PW'(1) : iq_rd_q);
    iq_cnt_d = iq_cnt_q;
    if (redirect)         iq_cnt_d = '0;
    else if (push && !pop) iq_cnt_d = iq_cnt_q + CW'(1);
    else if (pop && !push) iq_cnt_d = iq_cnt_q - CW'(1);

    ins_d = ins_q;
    pa_d  = pa_q;
    vld_d = vld_q;
    if (if_en) begin
      if (pop) begin
        ins_d = iq_data_q[iq_rd_q];
        pa_d  = iq_addr_q[iq_rd_q];
        vld_d = 1'b1;
      end else begin
        ins_d = NOP_INS;
        vld_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      pc_q     <= RESET_ADDR;
      out_q    <= '0;
      disc_q   <= '0;
      af_rd_q  <= '0;
      af_wr_q  <= '0;
      iq_rd_q  <= '0;
      iq_wr_q  <= '0;
      iq_cnt_q <= '0;
      ins_q    <= NOP_INS;
      pa_q     <= '0;
      vld_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      out_q    <= out_d;
      disc_q   <= disc_d;
      af_rd_q  <= af_rd_d;
      af_wr_q  <= af_wr_d;
      iq_rd_q  <= iq_rd_d;
      iq_wr_q  <= iq_wr_d;
      iq_cnt_q <= iq_cnt_d;
      ins_q    <= ins_d;
      pa_q     <= pa_d;
      vld_q    <= vld_d;
    end
  end

  // Storage arrays need no reset; pointers and counts qualify their contents.
  always_ff @(posedge clk_i) begin
    if (acc && !redirect) af_mem_q[af_wr_q] <= pc_q;
    if (push) begin
      iq_addr_q[iq_wr_q] <= af_mem_q[af_rd_q];
      iq_data_q[iq_wr_q] <= imem_rdata_i;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:       if (!dbg_i) state_d = RUN;
      RUN, DRAIN: if (!dbg_i) state_d = (disc_d != '0) ? DRAIN : RUN;
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    issue_en = (state_q != IDLE);
  end

  assign ins_o             = ins_q;
  assign if_id_pres_addr_o = pa_q;
  assign if_id_valid_o     = vld_q;

  // A response with nothing in flight is a memory protocol error.
  assert property (@(posedge clk_i) disable iff (rst_i) !(imem_rvalid_i && out_q == '0));

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Self-checking bench for fetch_queue_stage: queue-level reference model
// compared every cycle, plus directed literal checks.
module tb_fetch_queue_stage;

  localparam int          DEPTH = 2;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] RADDR = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst, dbg, mem_hold, hz, branch, trap, gnt, rvalid;
  logic [31:0] branch_target, trap_addr, rdata;
  logic        req, valid;
  logic [31:0] addr, ins, pa;

  int n_cmp = 0;
  int n_err = 0;

  fetch_queue_stage #(.ADDR_W(32), .DEPTH(DEPTH), .RESET_ADDR(RADDR), .NOP_INS(NOP)) dut (
    .clk_i(clk), .rst_i(rst), .dbg_i(dbg), .mem_hold_i(mem_hold), .hz_i(hz),
    .branch_i(branch), .branch_target_i(branch_target),
    .trap_i(trap), .trap_addr_i(trap_addr),
    .imem_req_o(req), .imem_addr_o(addr), .imem_gnt_i(gnt),
    .imem_rvalid_i(rvalid), .imem_rdata_i(rdata),
    .ins_o(ins), .if_id_pres_addr_o(pa), .if_id_valid_o(valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] f(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory: every accepted request answers one cycle later unless stalled.
  logic [31:0] mem_q[$];
  bit          resp_stall = 1'b0;

  // Reference model state
  bit          m_started;
  logic [31:0] m_pc, m_ins, m_pa;
  logic        m_v;
  int          m_out, m_disc;
  logic [31:0] m_aq[$];
  logic [63:0] m_iq[$];
  logic        m_req, m_acc, m_rsp, m_redir, m_en;
  logic [31:0] m_tgt, m_a;
  logic [63:0] m_e;

  task automatic model_reset();
    m_started = 1'b0; m_pc = RADDR; m_ins = NOP; m_pa = '0; m_v = 1'b0;
    m_out = 0; m_disc = 0; m_aq.delete(); m_iq.delete();
  endtask

  always @(negedge clk) begin
    if (rst) model_reset();
    m_req = m_started && !dbg && ((m_out + m_iq.size()) < DEPTH);
    chk("imem_req", {31'b0, req}, {31'b0, m_req});
    chk("imem_addr", addr, m_pc);
    chk("ins", ins, m_ins);
    chk("pres_addr", pa, m_pa);
    chk("valid", {31'b0, valid}, {31'b0, m_v});
    if (!rst) begin
      if (req && gnt) mem_q.push_back(addr);
      m_acc   = m_req && gnt;
      m_rsp   = rvalid && (m_out > 0);
      m_redir = !dbg && (trap || branch);
      m_tgt   = trap ? trap_addr : branch_target;
      m_en    = !dbg && !mem_hold && !hz;
      if (m_en) begin
        if (!m_redir && m_iq.size() > 0) begin
          m_e = m_iq.pop_front();
          m_pa = m_e[63:32]; m_ins = m_e[31:0]; m_v = 1'b1;
        end else begin
          m_ins = NOP; m_v = 1'b0;
        end
      end
      if (m_rsp) begin
        m_out--;
        if (m_disc > 0) m_disc--;
        else begin
          m_a = m_aq.pop_front();
          m_iq.push_back({m_a, rdata});
        end
      end
      if (m_acc) begin
        m_aq.push_back(m_pc);
        m_pc = m_pc + 32'd4;
        m_out++;
      end
      if (m_redir) begin
        m_pc = m_tgt; m_iq.delete(); m_aq.delete(); m_disc = m_out;
      end
      if (!dbg) m_started = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (!resp_stall && mem_q.size() > 0) begin
      rvalid = 1'b1;
      rdata  = f(mem_q.pop_front());
    end else begin
      rvalid = 1'b0;
      rdata  = '0;
    end
  endtask

  task automatic wait_valid(input string name, input logic [31:0] exp_pa, input logic [31:0] exp_ins);
    bit found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      tick();
      if (valid === 1'b1) found = 1'b1;
    end
    if (!found) begin
      n_cmp++; n_err++;
      $display("FAIL %s_timeout: no valid instruction within 30 cycles, expected addr %h", name, exp_pa);
    end else begin
      chk({name, "_pa"}, pa, exp_pa);
      chk({name, "_ins"}, ins, exp_ins);
    end
  endtask

  initial begin
    rst = 1'b1; dbg = 1'b0; mem_hold = 1'b0; hz = 1'b0; branch = 1'b0; trap = 1'b0;
    gnt = 1'b1; rvalid = 1'b0; rdata = '0; branch_target = '0; trap_addr = '0;
    repeat (3) tick();
    chk("rst_ins", ins, NOP);
    chk("rst_addr", addr, RADDR);
    rst = 1'b0;

    // Startup latency with a one-cycle memory
    chk("idle_req", {31'b0, req}, 32'd0);
    tick(); chk("c1_req", {31'b0, req}, 32'd1); chk("c1_addr", addr, 32'h100);
    tick(); chk("c2_addr", addr, 32'h104);
    tick(); chk("c3_req", {31'b0, req}, 32'd0); chk("c3_valid", {31'b0, valid}, 32'd0);
    tick(); chk("c4_ins", ins, 32'h0100_FEFF); chk("c4_pa", pa, 32'h100);
    chk("c4_valid", {31'b0, valid}, 32'd1);
    repeat (6) tick();

    // Hazard stall fills the queue
    hz = 1'b1;
    tick(); tick();
    chk("hz_full_req", {31'b0, req}, 32'd0);
    tick(); hz = 1'b0;
    repeat (6) tick();

    // Branch with two requests outstanding
    resp_stall = 1'b1;
    repeat (4) tick();
    chk("br_req_blocked", {31'b0, req}, 32'd0);
    branch = 1'b1; branch_target = 32'h200;
    tick(); branch = 1'b0; resp_stall = 1'b0;
    chk("br_bubble_ins", ins, NOP);
    chk("br_bubble_valid", {31'b0, valid}, 32'd0);
    chk("br_pc", addr, 32'h200);
    wait_valid("br_first", 32'h200, 32'h0200_FDFF);
    repeat (3) tick();

    // Trap wins over branch
    trap = 1'b1; trap_addr = 32'h40; branch = 1'b1; branch_target = 32'h200;
    tick(); trap = 1'b0; branch = 1'b0;
    chk("trap_pc", addr, 32'h40);
    wait_valid("trap_first", 32'h40, 32'h0040_FFBF);

    // Grant withheld for four cycles
    repeat (4) tick();
    gnt = 1'b0;
    repeat (3) tick();
    chk("nognt_bubble", {31'b0, valid}, 32'd0);
    tick(); gnt = 1'b1;
    repeat (4) tick();

    // Memory hold
    mem_hold = 1'b1;
    tick(); tick(); mem_hold = 1'b0;
    repeat (4) tick();

    // Debug freeze ignores a redirect
    dbg = 1'b1; branch = 1'b1; branch_target = 32'h300;
    #1 chk("dbg_req", {31'b0, req}, 32'd0);
    repeat (3) tick();
    dbg = 1'b0; branch = 1'b0;
    repeat (4) tick();

    // PC wrap
    trap = 1'b1; trap_addr = 32'hFFFF_FFFC;
    tick(); trap = 1'b0;
    wait_valid("wrap_top", 32'hFFFF_FFFC, 32'hFFFC_0003);
    wait_valid("wrap_zero", 32'h0, 32'h0000_FFFF);

    // Asynchronous reset mid-cycle
    repeat (3) tick();
    #2 rst = 1'b1;
    #1;
    chk("arst_ins", ins, NOP);
    chk("arst_valid", {31'b0, valid}, 32'd0);
    chk("arst_pa", pa, 32'h0);
    chk("arst_req", {31'b0, req}, 32'd0);
    chk("arst_addr", addr, RADDR);
    mem_q.delete(); rvalid = 1'b0;
    tick(); tick(); rst = 1'b0;
    repeat (8) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_queue_stage.md
Name: fetch_queue_stage

Overview:
- Instruction fetch stage directly upstream of the decode stage.
- Generates the PC and issues requests to instruction memory through a req/gnt/rvalid handshake.
- Buffers returned instructions in a small in-order queue and drives the IF/ID pipeline register (ins, IF_ID_pres_addr) that decode consumes.
- Honours decode's hazard stall, branch redirect, trap redirect, debug freeze and memory hold.

Parameters:
- ADDR_W, 32: PC / instruction address width.
- DEPTH, 2: instruction queue depth; also the maximum number of outstanding requests; power of two, ≥2.
- RESET_ADDR, 0: PC value after reset.
- NOP_INS, 32'h00000013: bubble instruction (addi x0,x0,0).

Ports:
- clk  in  1  system clock.
- Rst  in  1  asynchronous active-high reset.
- dbg  in  1  debug freeze; stops all state updates.
- mem_hold  in  1  data-memory hold; freezes the IF/ID register only.
- hz  in  1  decode hazard stall; holds the IF/ID register.
- branch  in  1  branch/jump taken in decode.
- branch_target  in  ADDR_W  redirect address for branch.
- trap  in  1  trap/ecall redirect request.
- trap_addr  in  ADDR_W  trap vector address.
- imem_req  out  1  fetch request valid.
- imem_addr  out  ADDR_W  fetch address.
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  response data valid; responses return in order.
- imem_rdata  in  32  response instruction.
- ins  out  32  IF/ID instruction to decode.
- IF_ID_pres_addr  out  ADDR_W  IF/ID instruction address.
- IF_ID_valid  out  1  IF/ID holds a real instruction, not a bubble.

Behaviour:
- Reset: asynchronous, active-high, applies immediately.
  - PC=RESET_ADDR, imem_req=0, imem_addr=RESET_ADDR.
  - Queue empty, outstanding=0, discard=0.
  - ins=NOP_INS, IF_ID_pres_addr=0, IF_ID_valid=0, state=IDLE.
- FSM:
  - IDLE: one cycle after reset deassertion, then RUN.
  - RUN: normal fetch.
  - DRAIN: entered on a redirect while discard>0; returns to RUN when discard reaches 0.
  - Fetching at the new PC continues in DRAIN; discard counts only stale responses.
- Issue rule: imem_req = (state≠IDLE) && !dbg && (outstanding + queue_count < DEPTH). imem_addr=PC (combinational from the PC register).
- Request acceptance (req && gnt): PC<=PC+4, wrapping modulo 2^ADDR_W. The accepted address is pushed into an address FIFO of DEPTH entries.
- Response (rvalid):
  - If discard>0: decrement discard and drop the data.
  - Else: pop the address FIFO and push {addr, rdata} into the instruction queue.
  - outstanding decrements on every response; it increments on acceptance.
  - Simultaneous acceptance and response leave outstanding unchanged.
- Redirect: redirect = trap || branch; trap has priority (target = trap_addr, else branch_target). Redirect is ignored while dbg=1. In the redirect cycle:
  - PC<=target.
  - Queue and address FIFO cleared.
  - discard <= outstanding after this cycle's acceptance/response, minus any response already being discarded.
  - imem_req in the redirect cycle still uses the old PC. If that request is accepted it is counted into discard.
  - IF/ID loads the bubble (NOP_INS, valid=0) if its update is enabled that cycle; otherwise it holds.
- IF/ID update enable: !dbg && !mem_hold && !hz.
  - When enabled and no redirect: if the queue is non-empty, pop into ins/IF_ID_pres_addr with valid=1; else load the bubble with valid=0.
  - When not enabled: hold all three outputs.
  - A queue pop and push in the same cycle are both allowed when the queue is full.
- Bypass: a response arriving with an empty queue and IF/ID enabled goes through the queue. Minimum latency from gnt to ins is the memory latency + 1 cycle.
- dbg=1: PC, queue, FIFO, counters, FSM and IF/ID all hold; imem_req=0. Responses to requests already in flight during dbg are still accepted into the queue or discard; capacity is guaranteed by the issue rule.
- Overflow is impossible by construction. An rvalid arriving with outstanding=0 is a protocol error; it is ignored and flagged by a simulation assertion.

Test Plan:
- Reset → RESET_ADDR=0x100: after Rst falls, imem_addr=0x100, 0x104, …; with 1-cycle memory latency ins shows 0x100's word with IF_ID_pres_addr=0x100, valid=1, 3 cycles after the first gnt, then one instruction per cycle.
- hz=1 for 3 cycles mid-stream: ins and IF_ID_pres_addr constant; queue fills to DEPTH and imem_req drops; after release, addresses continue without loss or duplication.
- branch=1 with branch_target=0x200 and 2 requests outstanding: next IF/ID is NOP_INS, valid=0; the 2 stale responses are dropped; the first valid instruction has IF_ID_pres_addr=0x200.
- trap and branch in the same cycle (trap_addr=0x40, branch_target=0x200): fetch resumes at 0x40.
- imem_gnt low for 4 cycles: imem_req and imem_addr stay stable; IF/ID emits bubbles once the queue empties.
- mem_hold=1 for 2 cycles, and a separate case with PC=0xFFFFFFFC: IF/ID holds while the queue fills; PC wraps to 0x0; asserting Rst mid-stream clears outputs in the same cycle without waiting for a clock edge.
